// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: width, FSM states
// and the step counter width.
package div_pkg;
    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not go negative.
module div_step
    import div_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W:0]   rem_in,
    input  logic         msb_in,
    input  logic [W-1:0] divisor,
    output logic [W:0]   rem_out,
    output logic         q_bit
);
    logic [W+1:0] w_shift;
    logic [W+1:0] w_trial;

    // One spare top bit on the trial so its sign tells us whether to restore.
    assign w_shift = {rem_in, msb_in};
    assign w_trial = w_shift - {2'b00, divisor};
    assign q_bit   = ~w_trial[W+1];
    assign rem_out = q_bit ? w_trial[W:0] : w_shift[W:0];
endmodule

// File: rtl/div.sv
// 8-bit unsigned sequential divider: start/done handshake, one quotient bit per
// clock, result registered on C/R/dbz and held until the next completion.
module div
    import div_pkg::*;
#(
    parameter int WIDTH = div_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             dbz
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_r;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic [WIDTH:0]   w_rem;
    logic             w_q;

    div_step #(.W(WIDTH)) u_step (
        .rem_in  (r_rem),
        .msb_in  (r_dvd[WIDTH-1]),
        .divisor (r_dvs),
        .rem_out (w_rem),
        .q_bit   (w_q)
    );

    // Quotient bits shift into the low end of the dividend register as the
    // dividend bits leave the top, so after WIDTH steps it holds the quotient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_c     <= '0;
            r_r     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_dvd   <= A;
                        r_dvs   <= B;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_rem <= w_rem;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_q};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_c     <= {r_dvd[WIDTH-2:0], w_q};
                        r_r     <= w_rem[WIDTH-1:0];
                        r_dbz   <= (r_dvs == '0);
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // The edge leaving DONE is the first one that may accept a
                    // new request, giving one division per WIDTH+1 cycles.
                    r_done <= 1'b0;
                    if (start) begin
                        r_dvd   <= A;
                        r_dvs   <= B;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign C    = r_c;
    assign R    = r_r;
    assign busy = r_busy;
    assign done = r_done;
    assign dbz  = r_dbz;
endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: a timing/arithmetic model queues expected results
// on accept, a negedge monitor checks done/busy/C/R/dbz every cycle.
module tb_div;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic [7:0] C;
    logic [7:0] R;
    logic       busy;
    logic       done;
    logic       dbz;

    div dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .C(C), .R(R), .busy(busy), .done(done), .dbz(dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] c;
        logic [7:0] r;
        logic       z;
        int         de;
    } exp_t;

    exp_t q[$];
    int   edge_n  = 0;
    int   free_at = 0;
    int   checks  = 0;
    int   fails   = 0;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s act=%0d exp=%0d edge=%0d", n, act, exp, edge_n);
        end
    endtask

    // Reference: plain division, B==0 yields all-ones quotient and R=A.
    // A request is taken on any edge where the previous one has fully retired.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            free_at = 0;
        end else begin
            edge_n++;
            if (start && edge_n >= free_at) begin
                exp_t e;
                e.z  = (B == 0);
                e.c  = e.z ? 8'hFF : A / B;
                e.r  = e.z ? A : A % B;
                e.de = edge_n + 8;
                q.push_back(e);
                free_at = edge_n + 9;
            end
        end
    end

    logic [7:0] hc = '0, hr = '0;
    logic       hz = 1'b0;

    always @(negedge clk) begin
        bit exp_done;
        exp_done = 1'b0;
        if (!rst_n) begin
            hc = '0; hr = '0; hz = 1'b0;
        end else if (q.size() > 0 && q[0].de == edge_n) begin
            exp_t e;
            e = q.pop_front();
            hc = e.c; hr = e.r; hz = e.z;
            exp_done = 1'b1;
        end
        chk("done", done, exp_done);
        chk("busy", busy, (rst_n && edge_n < free_at) ? 1 : 0);
        chk("C", C, hc);
        chk("R", R, hr);
        chk("dbz", dbz, hz);
    end

    task automatic op(input logic [7:0] a, input logic [7:0] b);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 8'($urandom); B = 8'($urandom);
    endtask

    task automatic idle9();
        repeat (9) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] da [8];
        logic [7:0] db [8];
        da = '{8'd3, 8'd255, 8'd200, 8'd5, 8'd42, 8'd0, 8'd255, 8'd0};
        db = '{8'd2, 8'd1,   8'd7,   8'd9, 8'd0,  8'd0, 8'd255, 8'd1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_C", C, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            op(da[i], db[i]);
            idle9();
        end

        // Start pulse mid-run with other operands must be ignored.
        op(8'd100, 8'd3);
        repeat (2) @(posedge clk);
        #1;
        A = 8'd77; B = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Held start: back-to-back accepts, operands changing every cycle.
        start = 1'b1;
        repeat (40) begin
            A = 8'($urandom); B = 8'($urandom_range(0, 20));
            @(posedge clk); #1;
        end
        start = 1'b0;
        idle9();

        // Asynchronous reset at step 4 aborts with no done.
        op(8'd3, 8'd2);
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_C", C, 0);
        chk("abort_R", R, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_dbz", dbz, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op(8'd100, 8'd10);
        idle9();

        // Random traffic with gaps, bursts and occasional zero divisors.
        repeat (6000) begin
            start = ($urandom_range(0, 3) != 0);
            A = 8'($urandom);
            B = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk); #1;
        chk("drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
